cc_cond_unit: RTL and testbench

Execute-stage back end of the Y86-64 pipeline: consumes the 64-bit ALU result and overflow flag, maintains the architectural condition-code register (ZF/SF/OF), and evaluates branch/cmov conditions for the instruction in E. It also owns the E→M pipeline register, so the Memory stage receives valE, the condition-gated dstE, Cnd, and the pass-through fields. It sits between the ALU and the Memory stage and is driven by pipeline control.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/cond_eval.sv | 35 +++
 rtl/cc_cond_unit.sv | 100 ++++++++++
 tb/tb_cc_cond_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the Execute-to-Memory pipeline bundle.
package y86_pkg;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    localparam logic [3:0] C_YES   = 4'd0;
    localparam logic [3:0] C_LE    = 4'd1;
    localparam logic [3:0] C_L     = 4'd2;
    localparam logic [3:0] C_E     = 4'd3;
    localparam logic [3:0] C_NE    = 4'd4;
    localparam logic [3:0] C_GE    = 4'd5;
    localparam logic [3:0] C_G     = 4'd6;

    typedef struct packed {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_bundle_t;

    localparam m_bundle_t M_NOP = '{
        icode: INOP,
        stat:  SAOK,
        cnd:   1'b0,
        valE:  64'd0,
        valA:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE
    };

endpackage

// File: rtl/cond_eval.sv
// Branch/cmov condition from the {ZF,SF,OF} flags and the ifun field.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf_s;
    logic sf_s;
    logic of_s;
    logic lt_s;

    assign zf_s = cc[2];
    assign sf_s = cc[1];
    assign of_s = cc[0];
    assign lt_s = sf_s ^ of_s;

    // Decode the condition function; unused encodings evaluate false.
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt_s | zf_s;
            C_L:     cnd = lt_s;
            C_E:     cnd = zf_s;
            C_NE:    cnd = ~zf_s;
            C_GE:    cnd = ~lt_s;
            C_G:     cnd = ~lt_s & ~zf_s;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_cond_unit.sv
// Execute-stage back end: condition codes, condition evaluation, cmov
// destination gating and the E-to-M pipeline register.
module cc_cond_unit
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_valid,
    input  logic [3:0]  e_icode,
    input  logic [3:0]  e_ifun,
    input  logic [2:0]  e_stat,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic [63:0] alu_result,
    input  logic        alu_overflow,
    input  logic        cc_inhibit,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic [2:0]  cc,
    output logic        e_cnd,
    output logic [3:0]  e_dstE_eff,
    output logic [3:0]  M_icode,
    output logic [2:0]  M_stat,
    output logic        M_cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
);

    logic [2:0] cc_q;
    logic [2:0] cc_d;
    m_bundle_t  m_q;
    m_bundle_t  m_d;
    logic       set_cc_s;
    logic       cnd_raw_s;

    assign set_cc_s = e_valid & (e_icode == IOPQ) & ~cc_inhibit;

    // Conditions read the pre-edge flags, so a jXX right after an OPq
    // sees the flags that OPq wrote on the intervening edge.
    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (e_ifun),
        .cnd  (cnd_raw_s)
    );

    assign e_cnd      = e_valid & cnd_raw_s;
    assign e_dstE_eff = ((e_icode == ICMOVXX) && !e_cnd) ? RNONE : e_dstE;

    // Next condition-code value.
    always_comb begin
        cc_d = cc_q;
        if (set_cc_s) begin
            cc_d = {(alu_result == 64'd0), alu_result[63], alu_overflow};
        end else begin
            cc_d = cc_q;
        end
    end

    // Next M-register contents: stall beats bubble beats normal load.
    always_comb begin
        m_d = m_q;
        if (m_stall) begin
            m_d = m_q;
        end else if (m_bubble || !e_valid) begin
            m_d = M_NOP;
        end else begin
            m_d.icode = e_icode;
            m_d.stat  = e_stat;
            m_d.cnd   = e_cnd;
            m_d.valE  = alu_result;
            m_d.valA  = e_valA;
            m_d.dstE  = e_dstE_eff;
            m_d.dstM  = e_dstM;
        end
    end

    // Condition-code and M pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
            m_q  <= M_NOP;
        end else begin
            cc_q <= cc_d;
            m_q  <= m_d;
        end
    end

    assign cc      = cc_q;
    assign M_icode = m_q.icode;
    assign M_stat  = m_q.stat;
    assign M_cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed table-driven bench for cc_cond_unit with hand-computed expectations.
module tb_cc_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [2:0]  e_stat;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [63:0] alu_result;
    logic        alu_overflow;
    logic        cc_inhibit;
    logic        m_stall;
    logic        m_bubble;
    logic [2:0]  cc;
    logic        e_cnd;
    logic [3:0]  e_dstE_eff;
    logic [3:0]  M_icode;
    logic [2:0]  M_stat;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    int n_chk  = 0;
    int n_fail = 0;

    cc_cond_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .e_valid      (e_valid),
        .e_icode      (e_icode),
        .e_ifun       (e_ifun),
        .e_stat       (e_stat),
        .e_valA       (e_valA),
        .e_dstE       (e_dstE),
        .e_dstM       (e_dstM),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .cc_inhibit   (cc_inhibit),
        .m_stall      (m_stall),
        .m_bubble     (m_bubble),
        .cc           (cc),
        .e_cnd        (e_cnd),
        .e_dstE_eff   (e_dstE_eff),
        .M_icode      (M_icode),
        .M_stat       (M_stat),
        .M_cnd        (M_cnd),
        .M_valE       (M_valE),
        .M_valA       (M_valA),
        .M_dstE       (M_dstE),
        .M_dstM       (M_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [2:0]  st;
        logic [63:0] va;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [63:0] alu;
        logic        ov;
        logic        inh;
        logic        stl;
        logic        bub;
        logic        x_cnd;
        logic [3:0]  x_eff;
        logic [2:0]  x_cc;
        logic [3:0]  x_ic;
        logic [2:0]  x_st;
        logic        x_mcnd;
        logic [63:0] x_ve;
        logic [63:0] x_va;
        logic [3:0]  x_de;
        logic [3:0]  x_dm;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    function automatic vec_t mk(
        input logic v, input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] st,
        input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm, input logic [63:0] alu,
        input logic ov, input logic inh, input logic stl, input logic bub,
        input logic x_cnd, input logic [3:0] x_eff, input logic [2:0] x_cc,
        input logic [3:0] x_ic, input logic [2:0] x_st, input logic x_mcnd,
        input logic [63:0] x_ve, input logic [63:0] x_va, input logic [3:0] x_de, input logic [3:0] x_dm);
        vec_t r;
        r.v = v; r.ic = ic; r.fn = fn; r.st = st; r.va = va; r.de = de; r.dm = dm;
        r.alu = alu; r.ov = ov; r.inh = inh; r.stl = stl; r.bub = bub;
        r.x_cnd = x_cnd; r.x_eff = x_eff; r.x_cc = x_cc; r.x_ic = x_ic; r.x_st = x_st;
        r.x_mcnd = x_mcnd; r.x_ve = x_ve; r.x_va = x_va; r.x_de = x_de; r.x_dm = x_dm;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        e_valid      = r.v;
        e_icode      = r.ic;
        e_ifun       = r.fn;
        e_stat       = r.st;
        e_valA       = r.va;
        e_dstE       = r.de;
        e_dstM       = r.dm;
        alu_result   = r.alu;
        alu_overflow = r.ov;
        cc_inhibit   = r.inh;
        m_stall      = r.stl;
        m_bubble     = r.bub;
    endtask

    initial begin
        // Inputs: v ic fn st valA dstE dstM alu ov inh stall bub
        // Expected: cnd eff cc | M icode stat cnd valE valA dstE dstM
        vec[0]  = mk(1'b1, 4'h6, 4'h1, 3'd1, 64'hA0, 4'h2, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'h2, 3'b010, 4'h6, 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA0, 4'h2, 4'hF);
        vec[1]  = mk(1'b1, 4'h7, 4'h2, 3'd1, 64'hA1, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'hF, 3'b010, 4'h7, 3'd1, 1'b1, 64'h0, 64'hA1, 4'hF, 4'hF);
        vec[2]  = mk(1'b1, 4'h6, 4'h1, 3'd1, 64'hA2, 4'h2, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'h2, 3'b010, 4'h6, 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA2, 4'h2, 4'hF);
        vec[3]  = mk(1'b1, 4'h7, 4'h5, 3'd1, 64'hA3, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 4'hF, 3'b010, 4'h7, 3'd1, 1'b0, 64'h0, 64'hA3, 4'hF, 4'hF);
        vec[4]  = mk(1'b1, 4'h6, 4'h0, 3'd1, 64'hA4, 4'h4, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'h4, 3'b100, 4'h6, 3'd1, 1'b1, 64'h0, 64'hA4, 4'h4, 4'hF);
        vec[5]  = mk(1'b1, 4'h6, 4'h1, 3'd1, 64'hA5, 4'h4, 4'hF, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b1, 4'h4, 3'b100, 4'h6, 3'd1, 1'b1, 64'h8000_0000_0000_0000, 64'hA5, 4'h4, 4'hF);
        vec[6]  = mk(1'b1, 4'h2, 4'h4, 3'd1, 64'hA6, 4'h3, 4'hF, 64'h7, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 4'hF, 3'b100, 4'h2, 3'd1, 1'b0, 64'h7, 64'hA6, 4'hF, 4'hF);
        vec[7]  = mk(1'b1, 4'h6, 4'h0, 3'd1, 64'hA7, 4'h5, 4'hF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'h5, 3'b000, 4'h6, 3'd1, 1'b1, 64'h1, 64'hA7, 4'h5, 4'hF);
        vec[8]  = mk(1'b1, 4'h2, 4'h4, 3'd3, 64'hA8, 4'h3, 4'hF, 64'h9, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'h3, 3'b000, 4'h2, 3'd3, 1'b1, 64'h9, 64'hA8, 4'h3, 4'hF);
        vec[9]  = mk(1'b1, 4'h7, 4'h6, 3'd1, 64'hB1, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'hF, 3'b000, 4'h7, 3'd1, 1'b1, 64'h0, 64'hB1, 4'hF, 4'hF);
        vec[10] = mk(1'b1, 4'h7, 4'h8, 3'd1, 64'hA9, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 4'hF, 3'b000, 4'h7, 3'd1, 1'b0, 64'h0, 64'hA9, 4'hF, 4'hF);
        vec[11] = mk(1'b0, 4'h7, 4'h0, 3'd4, 64'hAA, 4'h3, 4'h5, 64'h3, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 4'h3, 3'b000, 4'h1, 3'd1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
        vec[12] = mk(1'b1, 4'h7, 4'h0, 3'd1, 64'hAB, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1,
                     1'b1, 4'hF, 3'b000, 4'h1, 3'd1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
        vec[13] = mk(1'b1, 4'h2, 4'h4, 3'd1, 64'hAC, 4'h3, 4'h6, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'h3, 3'b000, 4'h2, 3'd1, 1'b1, 64'h11, 64'hAC, 4'h3, 4'h6);
        vec[14] = mk(1'b1, 4'h7, 4'h3, 3'd2, 64'hAD, 4'hF, 4'hF, 64'h22, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b0, 4'hF, 3'b000, 4'h2, 3'd1, 1'b1, 64'h11, 64'hAC, 4'h3, 4'h6);
        vec[15] = mk(1'b1, 4'h7, 4'h0, 3'd1, 64'hAE, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b1, 4'hF, 3'b000, 4'h2, 3'd1, 1'b1, 64'h11, 64'hAC, 4'h3, 4'h6);
        vec[16] = mk(1'b1, 4'h6, 4'h0, 3'd1, 64'hAF, 4'h7, 4'hF, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0,
                     1'b1, 4'h7, 3'b100, 4'h2, 3'd1, 1'b1, 64'h11, 64'hAC, 4'h3, 4'h6);
        vec[17] = mk(1'b1, 4'h7, 4'h3, 3'd1, 64'hB0, 4'hF, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 4'hF, 3'b100, 4'h7, 3'd1, 1'b1, 64'h0, 64'hB0, 4'hF, 4'hF);

        rst_n = 1'b0;
        e_valid = 1'b1; e_icode = 4'h7; e_ifun = 4'h3; e_stat = 3'd1;
        e_valA = 64'h0; e_dstE = 4'hF; e_dstM = 4'hF;
        alu_result = 64'h0; alu_overflow = 1'b0;
        cc_inhibit = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cc", 64'(cc), 64'(3'b100));
        chk("reset_M_icode", 64'(M_icode), 64'(4'h1));
        chk("reset_M_dstE", 64'(M_dstE), 64'(4'hF));
        chk("reset_je_cnd", 64'(e_cnd), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i]);
            #1;
            chk($sformatf("v%0d_e_cnd", i), 64'(e_cnd), 64'(vec[i].x_cnd));
            chk($sformatf("v%0d_dstE_eff", i), 64'(e_dstE_eff), 64'(vec[i].x_eff));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cc", i), 64'(cc), 64'(vec[i].x_cc));
            chk($sformatf("v%0d_M_icode", i), 64'(M_icode), 64'(vec[i].x_ic));
            chk($sformatf("v%0d_M_stat", i), 64'(M_stat), 64'(vec[i].x_st));
            chk($sformatf("v%0d_M_cnd", i), 64'(M_cnd), 64'(vec[i].x_mcnd));
            chk($sformatf("v%0d_M_valE", i), M_valE, vec[i].x_ve);
            chk($sformatf("v%0d_M_valA", i), M_valA, vec[i].x_va);
            chk($sformatf("v%0d_M_dstE", i), 64'(M_dstE), 64'(vec[i].x_de));
            chk($sformatf("v%0d_M_dstM", i), 64'(M_dstM), 64'(vec[i].x_dm));
        end

        // Load non-reset state, then pulse rst_n between edges with stall held.
        @(negedge clk);
        e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h0; e_stat = 3'd1;
        e_valA = 64'h55; e_dstE = 4'h1; e_dstM = 4'hF;
        alu_result = 64'h1; alu_overflow = 1'b0;
        cc_inhibit = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_cc", 64'(cc), 64'(3'b000));
        chk("pre_rst_M_icode", 64'(M_icode), 64'(4'h6));
        #2;
        m_stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cc", 64'(cc), 64'(3'b100));
        chk("async_rst_M_icode", 64'(M_icode), 64'(4'h1));
        chk("async_rst_M_valE", M_valE, 64'h0);
        chk("async_rst_M_valA", M_valA, 64'h0);
        chk("async_rst_M_dstE", 64'(M_dstE), 64'(4'hF));
        chk("async_rst_M_cnd", 64'(M_cnd), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        m_stall = 1'b0;
        e_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_cc", 64'(cc), 64'(3'b100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
